bus_gate_arbiter: RTL

Round-robin arbiter that shares the processor's 16-bit internal bus among five bus drivers. It produces the registered one-hot select for the bus gate mux, inserts optional dead cycles between owners, and, when compiled in, revokes grants held too long. It sits between the control unit's gate-request lines and the bus mux select input.

---
 rtl/bus_arb_pkg.sv | 34 +++
 rtl/rr_priority_pick.sv | 45 ++++
 rtl/bus_gate_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the five-driver bus gate
//                arbiter: arbiter state encoding, requester count, owner
//                index type and the modulo-5 pointer wrap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

   // Number of bus drivers sharing the internal bus
   localparam int NUM_REQ = 5;

   // Binary owner index, wide enough for NUM_REQ drivers
   typedef logic [2:0] owner_t;

   // Arbiter states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Returns (base + offset) mod NUM_REQ, used to walk the rotating priority
   function automatic owner_t rr_wrap(input owner_t base, input int unsigned offset);
      int unsigned w_sum;
      w_sum = {29'd0, base} + offset;
      return owner_t'(w_sum % NUM_REQ);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Purely combinational round-robin selector. Starting at the
//                priority pointer and walking upward mod NUM_REQ, the first
//                requester that is set and not masked wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
   import bus_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_mask,
   input  owner_t             i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output owner_t             o_idx,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] w_cand;
   owner_t             w_slot;

   assign w_cand = i_req & ~i_mask;

   // Scan from the lowest-priority slot to the highest so the highest-priority hit is written last
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_slot   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_slot = rr_wrap(i_ptr, k);
         if (w_cand[w_slot]) begin
            o_onehot         = '0;
            o_onehot[w_slot] = 1'b1;
            o_idx            = w_slot;
            o_valid          = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_gate_arbiter.sv
// ============================================================================
//  Module      : bus_gate_arbiter
//  Description : Round-robin arbiter for the 16-bit internal bus. Produces a
//                registered one-hot gate select, optional dead cycles between
//                owners (GAP_CYCLES), and, when BUS_ARB_TIMEOUT_EN is defined,
//                a watchdog that revokes grants held for MAX_HOLD cycles.
//  Options     : `define BUS_ARB_TIMEOUT_EN to build the hold watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_gate_arbiter
   import bus_arb_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int MAX_HOLD   = 64
)(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [NUM_REQ-1:0] Req,
   output logic [NUM_REQ-1:0] Gnt,
   output logic               Busy,
   output logic [2:0]         Owner,
   output logic               Timeout
);

   // Gap counter reload: counts GAP_CYCLES-1 down to 0 while in GAP
   localparam logic [1:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

   arb_state_t         r_state,  w_state_nxt;
   logic [NUM_REQ-1:0] r_gnt,    w_gnt_nxt;
   owner_t             r_owner,  w_owner_nxt;
   owner_t             r_ptr,    w_ptr_nxt;
   logic [1:0]         r_gap,    w_gap_nxt;
   logic               r_busy;
   logic               w_grant_new;
   logic               w_owner_req;
   logic               w_hold_expire;

   logic [NUM_REQ-1:0] w_pick_mask;
   logic [NUM_REQ-1:0] w_pick_onehot;
   owner_t             w_pick_idx;
   logic               w_pick_valid;

   assign w_owner_req = Req[r_owner];

   rr_priority_pick u_pick (
      .i_req    (Req),
      .i_mask   (w_pick_mask),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int                HOLD_W       = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] c_HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   logic [HOLD_W-1:0]  r_hold;
   logic [HOLD_W-1:0]  w_hold_inc;
   logic [NUM_REQ-1:0] r_mask;
   logic               r_timeout;

   // Saturating increment so the counter can never wrap back under the limit
   assign w_hold_inc    = (r_hold == {HOLD_W{1'b1}}) ? r_hold : r_hold + 1'b1;
   // Revoke only while the owner still wants the bus; a voluntary drop is a normal release
   assign w_hold_expire = (r_state == OWN) && w_owner_req && (w_hold_inc == c_HOLD_LIMIT);
   // The current owner is never re-picked, and revoked drivers stay out until they re-request
   assign w_pick_mask   = r_mask | r_gnt;
   assign Timeout       = r_timeout;

   // Hold counter, revoke mask and timeout pulse
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_hold    <= '0;
         r_mask    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_grant_new) begin
            r_hold <= '0;
         end else if (r_state == OWN) begin
            r_hold <= w_hold_inc;
         end
         r_mask    <= (r_mask & Req) | (w_hold_expire ? r_gnt : '0);
         r_timeout <= w_hold_expire;
      end
   end
`else
   assign w_hold_expire = 1'b0;
   assign w_pick_mask   = r_gnt;
   assign Timeout       = 1'b0;
`endif

   // Next-state and next-grant decode
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_gap_nxt   = r_gap;
      w_grant_new = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_gnt_nxt   = w_pick_onehot;
               w_owner_nxt = w_pick_idx;
               w_ptr_nxt   = rr_wrap(w_pick_idx, 1);
               w_state_nxt = OWN;
               w_grant_new = 1'b1;
            end
         end
         OWN: begin
            if (!w_owner_req || w_hold_expire) begin
               w_gnt_nxt = '0;
               if (GAP_CYCLES > 0) begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = c_GAP_LOAD;
               end else if (w_pick_valid) begin
                  // Zero-gap handoff: arbitrate in the release cycle
                  w_gnt_nxt   = w_pick_onehot;
                  w_owner_nxt = w_pick_idx;
                  w_ptr_nxt   = rr_wrap(w_pick_idx, 1);
                  w_grant_new = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         GAP: begin
            w_gnt_nxt = '0;
            if (r_gap == 2'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap - 2'd1;
            end
         end
         default: begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, grant, owner and pointer registers
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_busy  <= |w_gnt_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   assign Gnt   = r_gnt;
   assign Busy  = r_busy;
   assign Owner = r_owner;

endmodule

`default_nettype wire
